llc_proxy_q: RTL
================

Name: llc_proxy_q

Overview:
- Parametrised successor to the single-slot LLC latency model.
- Sits between the crossbar LLC-side ports and the testbench as a behavioural last-level-cache stand-in.
- Per port: in-order request FIFO (DEPTH entries), each request echoed as a reply after a programmable fixed latency.
- Unlike the single-slot model, multiple requests may be outstanding per port; replies can issue back-to-back.

Parameters:
- N_PORTS, 4, number of independent LLC ports.
- DATA_W, 64, request/reply payload width.
- DEPTH, 4, outstanding requests per port; power of two, >= 2.
- LAT_W, 4, width of one latency field.
- LAT_VEC, 16'h5032, packed per-port latencies; port i uses bits [LAT_W*i +: LAT_W]. Default gives 2, 3, 0, 5 for ports 0..3.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- llc_so  in  N_PORTS  xbar->LLC request valid.
- llc_ro  out  N_PORTS  LLC->xbar request ready.
- llc_do  in  N_PORTS*DATA_W  request data; port i at [DATA_W*i +: DATA_W].
- llc_si_r  out  N_PORTS  LLC->xbar reply valid.
- llc_ri_r  in  N_PORTS  xbar->LLC reply ready.
- llc_di_r  out  N_PORTS*DATA_W  reply data, packed as llc_do.
- llc_busy  out  N_PORTS  port FIFO non-empty.

Behaviour:
- Reset asserted (reset=0, asynchronous): all FIFOs empty, pointers and countdowns zero, payload regs zero.
  - Outputs during reset: llc_ro all 1, llc_si_r 0, llc_di_r 0, llc_busy 0.
  - Reset mid-operation discards all queued requests; nothing is replayed.
- Ports are fully independent; there is no cross-port arbitration.
- Push: llc_so[i] & llc_ro[i] at a rising edge writes llc_do slice i to the tail entry.
  - The entry's countdown loads LAT_i.
- Countdown: every cycle, each occupied entry with countdown > 0 decrements by 1; it saturates at 0.
  - Entries decrement even while not at the head.
- Reply valid: llc_si_r[i] = head occupied & head countdown == 0. Output is registered-state only, with no combinational path from inputs.
- llc_di_r slice i = head payload.
  - When empty, it holds the last popped value (0 after reset).
  - The value is don't-care while valid is 0, but it must not be X.
- Latency: request accepted at edge t -> llc_si_r high in the cycle following edge t+LAT_i. LAT_i=0 means visible right after edge t.
- Pop: llc_si_r[i] & llc_ri_r[i] at an edge frees the head entry.
  - If the next entry's countdown is already 0, llc_si_r stays high the following cycle with the new data (back-to-back replies).
- Ordering: strictly FIFO per port. A younger expired entry never bypasses an unexpired or unpopped head.
- llc_ro[i] = !full_i.
  - When full, ready is 0 even if a pop occurs that same edge; there is no pass-through.
  - A request presented while full stalls and is neither dropped nor duplicated.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged, and both operations complete in that cycle.
- Pointers: log2(DEPTH) bits plus a wrap bit. Full when indices match and wrap bits differ. Wrap-around is seamless.
- llc_busy[i] = occupancy != 0.
- llc_ri_r while llc_si_r is low has no effect. llc_do is ignored when llc_so is low.

Optional Feature:
- Macro LLC_PROXY_STATS_EN.
- When defined, two output ports are added:
  - stat_req  out  N_PORTS*16: accepted requests per port.
  - stat_stall  out  N_PORTS*16: cycles with llc_so[i]=1 & llc_ro[i]=0.
- Both counters wrap at 16 bits and are cleared by reset.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single request, defaults: port0 llc_so pulse with data 64'hA5, ri held 1 -> llc_si_r[0] high exactly 2 cycles after the accept edge with data A5, then low; ports 1/2/3 show the same with latencies 3/0/5.
- Burst of 4 into port1 (data 1..4) with ri=1 -> ro drops only if full. Replies 1,2,3,4 appear on 4 consecutive cycles, the first 3 cycles after the first accept.
- Fill port3 with 4 requests, ri=0 -> llc_ro[3]=0 from the edge of the 4th accept. A 5th request (data 5) is held. Raise ri -> replies 1..4 in order, then 5 is accepted; no loss, no duplicate.
- Port2 (LAT 0): push and pop every cycle for 20 cycles with incrementing data -> si_r continuously high after the first edge, data sequence intact, pointers wrap cleanly (>4 cycles).
- Reset asserted asynchronously mid-burst with 3 entries queued on port0 -> llc_si_r/llc_busy go 0 immediately and llc_ro goes 1. After release, a new request gets latency 2 and none of the old data appears.
- With LLC_PROXY_STATS_EN: the full-FIFO scenario above reports stat_req[3]=5 and stat_stall[3] equal to the held cycles.

Source files
------------

// File: rtl/llc_proxy_q.sv
// Multi-port behavioural LLC stand-in: per-port in-order FIFO that echoes each request after a fixed latency.
// Optional per-port request/stall counters are compiled in with `define LLC_PROXY_STATS_EN.
module llc_proxy_q #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4,
    parameter int LAT_W   = 4,
    parameter logic [N_PORTS*LAT_W-1:0] LAT_VEC = 16'h5032
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          llc_so,
    output logic [N_PORTS-1:0]          llc_ro,
    input  logic [N_PORTS*DATA_W-1:0]   llc_do,
    output logic [N_PORTS-1:0]          llc_si_r,
    input  logic [N_PORTS-1:0]          llc_ri_r,
    output logic [N_PORTS*DATA_W-1:0]   llc_di_r,
    output logic [N_PORTS-1:0]          llc_busy
`ifdef LLC_PROXY_STATS_EN
    ,
    output logic [N_PORTS*16-1:0]       stat_req,
    output logic [N_PORTS*16-1:0]       stat_stall
`endif
);

    localparam int AW = $clog2(DEPTH);

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        localparam logic [LAT_W-1:0] LAT = LAT_VEC[LAT_W*p +: LAT_W];

        logic [AW:0]         r_wr;
        logic [AW:0]         r_rd;
        logic [DATA_W-1:0]   r_last;
        logic [DATA_W-1:0]   w_memArr [DEPTH];
        logic [LAT_W-1:0]    w_cntArr [DEPTH];
        logic [AW-1:0]       w_headIdx;
        logic [AW-1:0]       w_tailIdx;
        logic                w_empty;
        logic                w_full;
        logic                w_push;
        logic                w_pop;

        assign w_headIdx = r_rd[AW-1:0];
        assign w_tailIdx = r_wr[AW-1:0];
        assign w_empty   = (r_wr == r_rd);
        assign w_full    = (w_tailIdx == w_headIdx) && (r_wr[AW] != r_rd[AW]);
        assign w_push    = llc_so[p] && !w_full;
        assign w_pop     = llc_si_r[p] && llc_ri_r[p];

        assign llc_ro[p]   = !w_full;
        assign llc_busy[p] = !w_empty;
        assign llc_si_r[p] = !w_empty && (w_cntArr[w_headIdx] == '0);
        // An empty queue presents the last popped payload rather than a stale slot.
        assign llc_di_r[DATA_W*p +: DATA_W] = w_empty ? r_last : w_memArr[w_headIdx];

        // Every slot counts down independently, so a queued entry ages while waiting behind the head.
        for (genvar e = 0; e < DEPTH; e++) begin : g_ent
            logic [DATA_W-1:0] r_mem;
            logic [LAT_W-1:0]  r_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_mem <= '0;
                    r_cnt <= '0;
                end else if (w_push && (w_tailIdx == AW'(e))) begin
                    r_mem <= llc_do[DATA_W*p +: DATA_W];
                    r_cnt <= LAT;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - LAT_W'(1);
                end
            end

            assign w_memArr[e] = r_mem;
            assign w_cntArr[e] = r_cnt;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wr   <= '0;
                r_rd   <= '0;
                r_last <= '0;
            end else begin
                if (w_push) begin
                    r_wr <= r_wr + (AW+1)'(1);
                end
                if (w_pop) begin
                    r_rd   <= r_rd + (AW+1)'(1);
                    r_last <= w_memArr[w_headIdx];
                end
            end
        end

`ifdef LLC_PROXY_STATS_EN
        logic [15:0] r_req;
        logic [15:0] r_stall;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_req   <= '0;
                r_stall <= '0;
            end else begin
                r_req   <= r_req + 16'(w_push);
                r_stall <= r_stall + 16'(llc_so[p] && w_full);
            end
        end

        assign stat_req[16*p +: 16]   = r_req;
        assign stat_stall[16*p +: 16] = r_stall;
`endif
    end

endmodule
